// File: rtl/uart_rx_gen2.sv
// uart_rx_gen2: oversampling UART receiver (3-sample majority vote, runtime framing) with a
// valid/ready output. Define UART_RX_FIFO_EN to replace the holding register by a FIFO.
module uart_rx_gen2 #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic [DATA_W-1:0]     m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_par_err,
  output logic                  m_frm_err,
  output logic                  overrun,
  output logic                  break_det,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] r;
    r = l;
    if (int'(l) < 5) r = LEN_W'(5);
    else if (int'(l) > DATA_W) r = LEN_W'(DATA_W);
    return r;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic                  rx_p0, rx_p1;
  logic [2:0]            state;
  logic [PRESCALE_W-1:0] ec, p_l, half;
  logic [LEN_W-1:0]      bc, len_l;
  logic                  par_en_l, par_typ_l, stop2_l, brk_hold;
  logic                  smp0, smp1;
  logic [DATA_W-1:0]     data_r;
  logic                  pe_r, fe_r, par_bit_r, stop1_r;
  logic                  ec_wrap, at_s0, at_s1, at_dec, bit_dec;
  logic                  last_stop, frame_done, stop1_zero, brk_now, push, frm_fe, ovr_now;

  // Stage p0/p1: two-flop synchroniser; rx_p1 is the line the FSM sees
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx_in;
      rx_p1 <= rx_p0;
    end
  end

  assign half       = p_l >> 1;
  assign ec_wrap    = ec == (p_l - PRESCALE_W'(1));
  assign at_s0      = ec == (half - PRESCALE_W'(1));
  assign at_s1      = ec == half;
  assign at_dec     = ec == (half + PRESCALE_W'(1));
  assign bit_dec    = maj3(smp0, smp1, rx_p1);
  assign last_stop  = (state == S_STOP) && (!stop2_l || bc != '0);
  assign frame_done = last_stop && at_dec;
  assign stop1_zero = (bc == '0) ? ~bit_dec : stop1_r;
  assign brk_now    = (data_r == '0) && !par_bit_r && stop1_zero;
  assign push       = frame_done && !brk_now;
  assign frm_fe     = fe_r | ~bit_dec;
  assign busy       = state != S_IDLE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      ec       <= '0;
      bc       <= '0;
      brk_hold <= 1'b0;
    end else if (state == S_IDLE) begin
      ec <= '0;
      bc <= '0;
      if (brk_hold) begin
        if (rx_p1) brk_hold <= 1'b0;
      end else if (!rx_p1) begin
        state <= S_START;
      end
    end else begin
      ec <= ec_wrap ? '0 : ec + PRESCALE_W'(1);
      if (ec_wrap) bc <= bc + LEN_W'(1);
      case (state)
        S_START: begin
          if (at_dec && bit_dec) begin
            state <= S_IDLE;
          end else if (ec_wrap) begin
            state <= S_DATA;
            bc    <= '0;
          end
        end
        S_DATA: begin
          if (ec_wrap && bc == len_l - LEN_W'(1)) begin
            bc    <= '0;
            state <= par_en_l ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (ec_wrap) begin
            bc    <= '0;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          // The frame closes at the mid-bit decision so a new start edge can be caught early
          if (frame_done) begin
            state    <= S_IDLE;
            brk_hold <= brk_now;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Frame configuration tracks the inputs while idle and freezes once a start is seen
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      p_l       <= prescale;
      len_l     <= sat_len(data_len);
      par_en_l  <= par_en;
      par_typ_l <= par_typ;
      stop2_l   <= stop2;
      data_r    <= '0;
      pe_r      <= 1'b0;
      fe_r      <= 1'b0;
      par_bit_r <= 1'b0;
      stop1_r   <= 1'b0;
    end else begin
      if (at_s0) smp0 <= rx_p1;
      if (at_s1) smp1 <= rx_p1;
      if (at_dec) begin
        case (state)
          S_DATA: begin
            for (int i = 0; i < DATA_W; i++)
              if (bc == LEN_W'(i)) data_r[i] <= bit_dec;
          end
          S_PARITY: begin
            par_bit_r <= bit_dec;
            pe_r      <= bit_dec != ((^data_r) ^ par_typ_l);
          end
          S_STOP: begin
            if (!bit_dec) fe_r <= 1'b1;
            if (bc == '0) stop1_r <= ~bit_dec;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W+1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       fifo_cnt;
  logic              fifo_full, fifo_empty, pop, wr_en;
  logic [DATA_W+1:0] head;

  assign fifo_full  = fifo_cnt == (AW+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  assign pop        = !fifo_empty && m_ready;
  assign wr_en      = push && (!fifo_full || pop);
  assign ovr_now    = push && fifo_full && !pop;
  assign head       = fifo_mem[rd_ptr];
  assign m_valid    = !fifo_empty;
  assign m_data     = fifo_empty ? '0 : head[DATA_W-1:0];
  assign m_par_err  = !fifo_empty && head[DATA_W];
  assign m_frm_err  = !fifo_empty && head[DATA_W+1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= {frm_fe, pe_r, data_r};
  end
`else
  logic pop;

  assign pop     = m_valid && m_ready;
  assign ovr_now = push && m_valid && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_par_err <= 1'b0;
      m_frm_err <= 1'b0;
    end else if (push && (!m_valid || pop)) begin
      m_valid   <= 1'b1;
      m_data    <= data_r;
      m_par_err <= pe_r;
      m_frm_err <= frm_fe;
    end else if (pop) begin
      m_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      overrun   <= ovr_now;
      break_det <= frame_done && brk_now;
    end
  end

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Bench for uart_rx_gen2: directed and randomized serial frames; a reference model queues the
// expected {frm_err, par_err, data} per frame and a monitor pops on every handshake.
module tb_uart_rx_gen2;
  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;
  localparam int LEN_W      = 4;
  localparam int FIFO_DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic [LEN_W-1:0]      data_len;
  logic                  par_en, par_typ, stop2;
  logic [DATA_W-1:0]     m_data;
  logic                  m_valid, m_ready, m_par_err, m_frm_err, overrun, break_det, busy;

  uart_rx_gen2 #(
    .DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .data_len(data_len),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_par_err(m_par_err), .m_frm_err(m_frm_err), .overrun(overrun),
    .break_det(break_det), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_ovr = 0, obs_ovr = 0, exp_brk = 0, obs_brk = 0;
  logic [DATA_W+1:0] exp_q[$];
  bit   rdy_rand = 1'b1;
  logic rdy_force = 1'b1;

  always @(posedge clk) begin
    #1;
    m_ready = rdy_rand ? 1'($urandom % 2) : rdy_force;
  end

  // Monitor: pops the scoreboard on each handshake and counts sideband pulses
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (overrun) obs_ovr++;
      if (break_det) obs_brk++;
      if (m_valid && m_ready) begin
        logic [DATA_W+1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: got data=%0h pe=%0b fe=%0b, none required",
                   m_data, m_par_err, m_frm_err);
        end else begin
          e = exp_q.pop_front();
          if ({m_frm_err, m_par_err, m_data} !== e) begin
            errors++;
            $display("FAIL frame: got fe=%0b pe=%0b data=%0h, required fe=%0b pe=%0b data=%0h",
                     m_frm_err, m_par_err, m_data, e[DATA_W+1], e[DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    @(posedge clk);
    #1;
    rx_in = b;
    repeat (cycles - 1) @(posedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Reference model: derives the expected outcome from the frame contents, then sends the bits
  task automatic send_frame(input logic [DATA_W-1:0] d, input int len_in, input bit pen,
                            input bit pt, input bit s2, input int p, input bit bad_par,
                            input bit st1, input bit st2v, input bit deliver, input bit scramble);
    int len;
    logic [DATA_W-1:0] dm;
    bit exp_par, pbit, pe, fe, brk;
    len = (len_in < 5) ? 5 : ((len_in > DATA_W) ? DATA_W : len_in);
    dm = '0;
    for (int i = 0; i < len; i++) dm[i] = d[i];
    exp_par = 1'(($countones(dm) + int'(pt)) % 2);
    pbit = exp_par ^ bad_par;
    pe = pen && (pbit != exp_par);
    fe = !st1 || (s2 && !st2v);
    brk = (dm == 0) && (!pen || !pbit) && !st1;
    if (brk) exp_brk++;
    else if (deliver) exp_q.push_back({fe, pe, dm});
    prescale = PRESCALE_W'(p);
    data_len = LEN_W'(len_in);
    par_en = pen;
    par_typ = pt;
    stop2 = s2;
    drive_bit(1'b0, p);
    if (scramble) begin
      prescale = PRESCALE_W'($urandom_range(5, 63));
      data_len = LEN_W'($urandom);
      par_en = 1'($urandom);
      par_typ = 1'($urandom);
      stop2 = 1'($urandom);
    end
    for (int i = 0; i < len; i++) drive_bit(dm[i], p);
    prescale = PRESCALE_W'(p);
    data_len = LEN_W'(len_in);
    par_en = pen;
    par_typ = pt;
    stop2 = s2;
    if (pen) drive_bit(pbit, p);
    drive_bit(st1, p);
    if (s2) drive_bit(st2v, p);
    drive_bit(1'b1, 2 * p);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    rx_in = 1'b1;
    prescale = 6'd8;
    data_len = 4'd8;
    par_en = 1'b0;
    par_typ = 1'b0;
    stop2 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {m_valid, m_par_err, m_frm_err, overrun, break_det, busy, m_data}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);

    send_frame(8'h55, 8, 0, 0, 0, 8, 0, 1, 1, 1, 0);
    wait_drain("drain_0x55");
    send_frame(8'hA3, 8, 1, 0, 0, 16, 1, 1, 1, 1, 0);
    wait_drain("drain_parity");

    // Short low glitch must not produce a frame
    prescale = 6'd16;
    @(posedge clk);
    #1 rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_in = 1'b1;
    n = 0;
    while (!busy && n < 8) begin @(negedge clk); n++; end
    chk("glitch_busy_rise", busy, 1);
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    chk("glitch_busy_fall", busy, 0);
    repeat (32) @(posedge clk);
    send_frame(8'h3C, 8, 0, 0, 0, 16, 0, 1, 1, 1, 0);
    wait_drain("drain_0x3c");

    send_frame(8'h5A, 7, 0, 0, 1, 32, 0, 1, 0, 1, 0);
    wait_drain("drain_stop2");

    // Consumer stalled: capacity exceeded by exactly one frame
    rdy_rand = 1'b0;
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
`ifdef UART_RX_FIFO_EN
    for (int k = 0; k < FIFO_DEPTH + 1; k++)
      send_frame(8'(8'h11 * (k + 1)), 8, 0, 0, 0, 8, 0, 1, 1, k < FIFO_DEPTH, 0);
`else
    send_frame(8'h11, 8, 0, 0, 0, 8, 0, 1, 1, 1, 0);
    send_frame(8'h22, 8, 0, 0, 0, 8, 0, 1, 1, 0, 0);
`endif
    exp_ovr++;
    @(negedge clk);
    chk("stall_head_data", m_data, 8'h11);
    chk("stall_valid", m_valid, 1);
    chk("overrun_pulses", obs_ovr, exp_ovr);
    rdy_force = 1'b1;
    wait_drain("drain_stall");
    repeat (2) @(negedge clk);
    chk("valid_drops", m_valid, 0);
    rdy_rand = 1'b1;

    // Break: line low for 12 bit times
    prescale = 6'd8;
    data_len = 4'd8;
    par_en = 1'b0;
    stop2 = 1'b0;
    exp_brk++;
    drive_bit(1'b0, 96);
    drive_bit(1'b1, 16);
    @(negedge clk);
    chk("break_pulses", obs_brk, exp_brk);
    chk("break_no_valid", m_valid, 0);
    send_frame(8'hC3, 8, 0, 0, 0, 8, 0, 1, 1, 1, 0);
    wait_drain("drain_0xc3");

    for (int i = 0; i < 40; i++) begin
      logic [DATA_W-1:0] d;
      bit pen, pt, s2, bad, st1, st2v;
      d = DATA_W'($urandom);
      pen = 1'($urandom);
      pt = 1'($urandom);
      s2 = 1'($urandom);
      bad = ($urandom % 4) == 0;
      st1 = ($urandom % 6) != 0;
      st2v = ($urandom % 6) != 0;
      if (i % 10 == 3) begin
        d = '0;
        st1 = 1'b0;
        bad = pt;
      end
      send_frame(d, $urandom_range(0, 15), pen, pt, s2, $urandom_range(5, 20), bad, st1, st2v,
                 1, 1);
    end
    wait_drain("drain_random");

    // Reset in the middle of the data bits aborts the frame
    prescale = 6'd8;
    data_len = 4'd8;
    par_en = 1'b0;
    stop2 = 1'b0;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midframe_reset_outputs",
        {m_valid, m_par_err, m_frm_err, overrun, break_det, busy, m_data}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("midframe_no_delivery", m_valid, 0);

    chk("overrun_total", obs_ovr, exp_ovr);
    chk("break_total", obs_brk, exp_brk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
